fp16_sqrt2: RTL and testbench



---
 rtl/fp16_sqrt2_if.sv | 28 ++
 rtl/fp16_sqrt2.sv | 166 ++++++++++++++++
 tb/tb_fp16_sqrt2.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fp16_sqrt2_if.sv
// fp16_sqrt2_if: host-side strobe, shared data bus and result flags.
// The bus has a weak pull-up, so an undriven bus reads as all ones.
interface fp16_sqrt2_if;
  logic       ENABLE;
  tri1 [15:0] IO_DATA;
  logic       IS_NAN;
  logic       IS_PINF;
  logic       IS_NINF;
  logic       RESULT;

  modport master (
    output ENABLE,
    inout  IO_DATA,
    input  IS_NAN,
    input  IS_PINF,
    input  IS_NINF,
    input  RESULT
  );

  modport slave (
    input  ENABLE,
    inout  IO_DATA,
    output IS_NAN,
    output IS_PINF,
    output IS_NINF,
    output RESULT
  );
endinterface

// File: rtl/fp16_sqrt2.sv
// fp16_sqrt2: iterative binary16 square root, one truncated root bit per clock.
// Define SQRT2_PARTIAL_OUT_EN to show partial roots on IO_DATA while busy.
module fp16_sqrt2 (
  input  logic        CLK,
  input  logic        RESET,
  fp16_sqrt2_if.slave bus
);

  logic        loaded;
  logic [3:0]  counter;
  logic [15:0] op;
  logic        sign;
  logic [4:0]  res_exp;
  logic [21:0] rad;
  logic [11:0] rem;
  logic [10:0] root;
  logic        spec;
  logic [15:0] spec_val;
  logic        spec_nan;
  logic        spec_pinf;
  logic        result;
  logic        is_nan;
  logic        is_pinf;

  logic [4:0]  op_e;
  logic [9:0]  op_f;
  logic [3:0]  sh;
  logic [10:0] m11;
  logic [11:0] m12;
  logic signed [6:0] e_un;
  logic signed [6:0] e_ev;
  logic signed [6:0] e_half;
  logic [4:0]  e_res;
  logic        c_nan;
  logic        c_inf;
  logic        c_zero;

  assign op_e   = op[14:10];
  assign op_f   = op[9:0];
  assign c_nan  = (op_e == 5'h1F) && (op_f != 10'd0);
  assign c_inf  = (op_e == 5'h1F) && (op_f == 10'd0);
  assign c_zero = (op_e == 5'd0) && (op_f == 10'd0);

  // distance from the leading one of a subnormal to the hidden-bit slot
  always_comb begin
    sh = 4'd0;
    for (int i = 0; i < 10; i++)
      if (op_f[i]) sh = 4'(10 - i);
  end

  always_comb begin
    if (op_e == 5'd0) begin
      m11  = {1'b0, op_f} << sh;
      e_un = -7'sd14 - $signed({3'b000, sh});
    end else begin
      m11  = {1'b1, op_f};
      e_un = $signed({2'b00, op_e}) - 7'sd15;
    end
    if (e_un[0]) begin
      m12  = {m11, 1'b0};
      e_ev = e_un - 7'sd1;
    end else begin
      m12  = {1'b0, m11};
      e_ev = e_un;
    end
    e_half = e_ev >>> 1;
    e_res  = 5'(e_half + 7'sd15);
  end

  logic [13:0] rem_t;
  logic [13:0] trial;
  logic [11:0] diff;
  logic        ge;

  assign rem_t = {rem, rad[21:20]};
  assign trial = {1'b0, root, 2'b01};
  assign ge    = rem_t >= trial;
  // when ge holds the true difference fits in 12 bits
  assign diff  = rem_t[11:0] - trial[11:0];

  always_ff @(posedge CLK) begin
    if (RESET || !bus.ENABLE) begin
      loaded    <= 1'b0;
      counter   <= 4'd0;
      op        <= '0;
      sign      <= 1'b0;
      res_exp   <= '0;
      rad       <= '0;
      rem       <= '0;
      root      <= '0;
      spec      <= 1'b0;
      spec_val  <= '0;
      spec_nan  <= 1'b0;
      spec_pinf <= 1'b0;
      result    <= 1'b0;
      is_nan    <= 1'b0;
      is_pinf   <= 1'b0;
    end else if (!loaded) begin
      loaded  <= 1'b1;
      counter <= 4'd1;
      op      <= bus.IO_DATA;
    end else begin
      unique case (1'b1)
        counter == 4'd1: begin
          counter <= 4'd2;
          sign    <= op[15];
          res_exp <= e_res;
          rad     <= {m12, 10'd0};
          rem     <= '0;
          root    <= '0;
          spec    <= 1'b1;
          unique case (1'b1)
            c_nan: begin
              spec_val <= op | 16'h0200;
              spec_nan <= 1'b1;
            end
            op[15] && !c_zero && !c_nan: begin
              spec_val <= 16'hFE00;
              spec_nan <= 1'b1;
            end
            c_inf && !op[15]: begin
              spec_val  <= 16'h7C00;
              spec_pinf <= 1'b1;
            end
            c_zero: spec_val <= {op[15], 15'd0};
            default: spec <= 1'b0;
          endcase
        end
        counter >= 4'd2 && counter <= 4'd12: begin
          counter <= counter + 4'd1;
          rad     <= {rad[19:0], 2'b00};
          rem     <= ge ? diff : rem_t[11:0];
          root    <= {root[9:0], ge};
          if (counter == 4'd12) begin
            result  <= 1'b1;
            is_nan  <= spec_nan;
            is_pinf <= spec_pinf;
          end
        end
        default: ;
      endcase
    end
  end

  logic [9:0]  shown;
  logic [15:0] dout;
  logic        show;

  assign shown = 10'(root << (4'd13 - counter));
  assign dout  = spec ? spec_val : {sign, res_exp, shown};

  always_comb begin
`ifdef SQRT2_PARTIAL_OUT_EN
    show = result || (counter >= 4'd2);
`else
    show = result;
`endif
  end

  assign bus.IO_DATA = (!RESET && bus.ENABLE && loaded && show) ? dout : 16'hzzzz;
  assign bus.RESULT  = result;
  assign bus.IS_NAN  = is_nan;
  assign bus.IS_PINF = is_pinf;
  assign bus.IS_NINF = 1'b0;

endmodule

// File: tb/tb_fp16_sqrt2.sv
// tb_fp16_sqrt2: scoreboard bench for the binary16 square-root peripheral.
// A released bus reads 16'hFFFF through the interface pull-up.
module tb_fp16_sqrt2;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] drv;
  logic        drv_en;
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct {
    logic [15:0] val;
    logic        nan;
    logic        pinf;
  } exp_t;

  exp_t sb[$];

  fp16_sqrt2_if bus ();

  fp16_sqrt2 dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  assign bus.IO_DATA = drv_en ? drv : 16'hzzzz;

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic run(input logic [15:0] din, input logic [15:0] want,
                     input logic nan, input logic pinf, input bit keep);
    exp_t e;
    int   lat;
    @(negedge CLK);
    bus.ENABLE = 1'b1;
    drv        = din;
    drv_en     = 1'b1;
    sb.push_back('{want, nan, pinf});
    @(posedge CLK);
    #1 drv_en = 1'b0;
    #1 check("load_hiz", bus.IO_DATA, 16'hFFFF);
    lat = 0;
    while (!bus.RESULT && lat < 20) begin
      @(posedge CLK);
      #1 lat++;
      if (lat == 6) check("busy_hiz", bus.IO_DATA, 16'hFFFF);
    end
    check("latency", 16'(lat), 16'd12);
    e = sb.pop_front();
    check("value", bus.IO_DATA, e.val);
    check("is_nan", 16'(bus.IS_NAN), 16'(e.nan));
    check("is_pinf", 16'(bus.IS_PINF), 16'(e.pinf));
    check("is_ninf", 16'(bus.IS_NINF), 16'd0);
    @(posedge CLK);
    #1 check("hold", bus.IO_DATA, e.val);
    if (!keep) begin
      @(negedge CLK);
      bus.ENABLE = 1'b0;
      #1 check("rel_hiz", bus.IO_DATA, 16'hFFFF);
      @(posedge CLK);
      #1 check("idle_res", 16'(bus.RESULT), 16'd0);
    end
  endtask

  task automatic start(input logic [15:0] din, input int cycles);
    @(negedge CLK);
    bus.ENABLE = 1'b1;
    drv        = din;
    drv_en     = 1'b1;
    @(posedge CLK);
    #1 drv_en = 1'b0;
    repeat (cycles) @(posedge CLK);
  endtask

  initial begin
    RESET      = 1'b1;
    bus.ENABLE = 1'b0;
    drv        = '0;
    drv_en     = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_res", 16'(bus.RESULT), 16'd0);
    check("rst_nan", 16'(bus.IS_NAN), 16'd0);
    check("rst_pinf", 16'(bus.IS_PINF), 16'd0);
    check("rst_ninf", 16'(bus.IS_NINF), 16'd0);
    check("rst_hiz", bus.IO_DATA, 16'hFFFF);
    @(negedge CLK) RESET = 1'b0;
    @(posedge CLK);
    #1 check("idle_hiz", bus.IO_DATA, 16'hFFFF);

    run(16'h3C00, 16'h3C00, 1'b0, 1'b0, 1'b0);
    run(16'h4000, 16'h3DA8, 1'b0, 1'b0, 1'b0);
    run(16'h4200, 16'h3EED, 1'b0, 1'b0, 1'b0);
    run(16'h4500, 16'h4078, 1'b0, 1'b0, 1'b0);
    run(16'h4700, 16'h414A, 1'b0, 1'b0, 1'b0);
    run(16'h3E00, 16'h3CE6, 1'b0, 1'b0, 1'b0);
    run(16'h3555, 16'h389E, 1'b0, 1'b0, 1'b0);
    run(16'h7BFF, 16'h5BFF, 1'b0, 1'b0, 1'b0);
    run(16'h0001, 16'h0C00, 1'b0, 1'b0, 1'b0);
    run(16'h0010, 16'h1400, 1'b0, 1'b0, 1'b0);
    run(16'h03FF, 16'h1FFE, 1'b0, 1'b0, 1'b0);
    run(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    run(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
    run(16'hC000, 16'hFE00, 1'b1, 1'b0, 1'b0);
    run(16'hBC00, 16'hFE00, 1'b1, 1'b0, 1'b0);
    run(16'hB800, 16'hFE00, 1'b1, 1'b0, 1'b0);
    run(16'hFC00, 16'hFE00, 1'b1, 1'b0, 1'b0);
    run(16'h7C00, 16'h7C00, 1'b0, 1'b1, 1'b0);
    run(16'h7E00, 16'h7E00, 1'b1, 1'b0, 1'b0);
    run(16'hFE00, 16'hFE00, 1'b1, 1'b0, 1'b0);
    run(16'h7C01, 16'h7E01, 1'b1, 1'b0, 1'b0);

    // abort at counter 6, then a fresh transaction
    start(16'h4200, 5);
    @(negedge CLK);
    bus.ENABLE = 1'b0;
    #1 check("abort_hiz", bus.IO_DATA, 16'hFFFF);
    @(posedge CLK);
    #1 check("abort_res", 16'(bus.RESULT), 16'd0);
    run(16'h4000, 16'h3DA8, 1'b0, 1'b0, 1'b0);

    // reset mid-computation with ENABLE held high
    start(16'h4500, 3);
    @(negedge CLK);
    RESET = 1'b1;
    #1 check("rstmid_hiz", bus.IO_DATA, 16'hFFFF);
    @(posedge CLK);
    #1 check("rstmid_res", 16'(bus.RESULT), 16'd0);
    @(negedge CLK);
    RESET      = 1'b0;
    bus.ENABLE = 1'b0;
    run(16'h4700, 16'h414A, 1'b0, 1'b0, 1'b0);

    // reset while a NaN result is held
    run(16'h7E00, 16'h7E00, 1'b1, 1'b0, 1'b1);
    @(negedge CLK);
    RESET = 1'b1;
    #1 check("rsthold_hiz", bus.IO_DATA, 16'hFFFF);
    @(posedge CLK);
    #1;
    check("rsthold_res", 16'(bus.RESULT), 16'd0);
    check("rsthold_nan", 16'(bus.IS_NAN), 16'd0);
    @(negedge CLK);
    RESET      = 1'b0;
    bus.ENABLE = 1'b0;
    run(16'h4000, 16'h3DA8, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
